spike_encoder: RTL and testbench

- Sits directly downstream of the digital neuron core and consumes its sampled membrane potential `v`, one sample per neuron step.
- Detects upward threshold crossings (spikes) and stamps each one with a step-count timestamp.
- Buffers spike events in a small FIFO and presents them on a valid/ready handshake to the readout/AER logic.
- Also keeps a saturating spike counter and the last inter-spike interval.

---
 rtl/spike_encoder.sv | 128 ++++++++++++
 tb/tb_spike_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Spike encoder: threshold-crossing detector with step timestamps, event FIFO,
// saturating spike counter and last inter-spike interval. Optional refractory window under SPIKE_ENC_REFRACTORY_EN.
module spike_encoder #(
  parameter int unsigned W         = 21,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned REF_STEPS = 3
) (
  input  logic                  clk,
  input  logic                  set,
  input  logic signed [W-1:0]   v_in,
  input  logic                  v_valid,
  input  logic signed [W-1:0]   th,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [TS_W-1:0]       ev_ts,
  output logic                  spike,
  output logic [CNT_W-1:0]      spike_cnt,
  output logic [TS_W-1:0]       last_isi,
  output logic                  ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_last;
  logic            prev_above;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];

  logic above_c;
  logic ref_ok_c;
  logic spike_det_c;
  logic empty_c;
  logic full_c;
  logic pop_c;
  logic wr_en_c;

  assign above_c     = (v_in >= th);
  assign spike_det_c = v_valid & above_c & ~prev_above & ref_ok_c;

`ifdef SPIKE_ENC_REFRACTORY_EN
  localparam int unsigned RC_W = (REF_STEPS < 1) ? 1 : $clog2(REF_STEPS + 1);

  logic [RC_W-1:0] ref_cnt;

  assign ref_ok_c = (ref_cnt == '0);

  // Refractory window: loaded on a spike, counts down one per sample
  always_ff @(posedge clk) begin
    if (set) begin
      ref_cnt <= '0;
    end else if (v_valid) begin
      if (spike_det_c)
        ref_cnt <= RC_W'(REF_STEPS);
      else if (ref_cnt != '0)
        ref_cnt <= ref_cnt - RC_W'(1);
    end
  end
`else
  logic unused_ref_steps;

  assign ref_ok_c         = 1'b1;
  assign unused_ref_steps = (REF_STEPS != 0);
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty_c  = (wr_ptr == rd_ptr);
  assign full_c   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c    = ~empty_c & ev_ready;
  assign wr_en_c  = spike_det_c & (~full_c | pop_c);

  assign ev_valid = ~empty_c;
  assign ev_ts    = mem[rd_ptr[AW-1:0]];

  // Step counter and crossing detection state
  always_ff @(posedge clk) begin
    if (set) begin
      ts         <= '0;
      prev_above <= 1'b0;
    end else if (v_valid) begin
      ts         <= ts + TS_W'(1);
      prev_above <= above_c;
    end
  end

  // Per-spike statistics and one-cycle spike pulse
  always_ff @(posedge clk) begin
    if (set) begin
      spike     <= 1'b0;
      spike_cnt <= '0;
      last_isi  <= '0;
      ts_last   <= '0;
      ovf       <= 1'b0;
    end else begin
      spike <= spike_det_c;
      if (spike_det_c) begin
        if (spike_cnt != '1)
          spike_cnt <= spike_cnt + CNT_W'(1);
        last_isi <= ts - ts_last;
        ts_last  <= ts;
        if (full_c && !pop_c)
          ovf <= 1'b1;
      end
    end
  end

  // Event FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (set) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr[AW-1:0]] <= ts;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop_c)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench for spike_encoder: detection, timestamps, FIFO
// back-pressure/overflow, signed threshold boundary, timestamp wrap, refractory and reset.
module tb_spike_encoder;

  localparam int unsigned W     = 21;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned CNT_W = 12;

  logic                clk;
  logic                set;
  logic signed [W-1:0] v_in;
  logic                v_valid;
  logic signed [W-1:0] th;
  logic                ev_valid;
  logic                ev_ready;
  logic [TS_W-1:0]     ev_ts;
  logic                spike;
  logic [CNT_W-1:0]    spike_cnt;
  logic [TS_W-1:0]     last_isi;
  logic                ovf;

  int total;
  int bad;

  spike_encoder dut (
    .clk       (clk),
    .set       (set),
    .v_in      (v_in),
    .v_valid   (v_valid),
    .th        (th),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_ts     (ev_ts),
    .spike     (spike),
    .spike_cnt (spike_cnt),
    .last_isi  (last_isi),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One neuron step: present a sample for one cycle; results are visible on return
  task automatic sample(input logic signed [W-1:0] v);
    v_in    = v;
    v_valid = 1'b1;
    tick();
    v_valid = 1'b0;
  endtask

  task automatic do_reset();
    set = 1'b1;
    tick();
    tick();
    set = 1'b0;
  endtask

  // Drain with ready held high, checking each head timestamp in order
  task automatic drain(input string tag, input int n, input int exp0, input int exp1,
                       input int exp2, input int exp3);
    int exp_ts [4];
    exp_ts[0] = exp0;
    exp_ts[1] = exp1;
    exp_ts[2] = exp2;
    exp_ts[3] = exp3;
    ev_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
      chk({tag, "_ts"}, 32'(ev_ts), 32'(exp_ts[i]));
      tick();
    end
    chk({tag, "_empty"}, 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;
  endtask

  initial begin
    int vals [7];
    int exp_sp [7];
    total    = 0;
    bad      = 0;
    set      = 1'b1;
    v_in     = '0;
    v_valid  = 1'b0;
    th       = '0;
    ev_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_cnt", 32'(spike_cnt), 32'd0);
    chk("rst_isi", 32'(last_isi), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Basic crossings: spikes at ts 2 and 5
    th       = 21'sd1000;
    ev_ready = 1'b1;
    sample(-21'sd500);
    chk("t1_s0_spike", 32'(spike), 32'd0);
    sample(21'sd200);
    chk("t1_s1_spike", 32'(spike), 32'd0);
    sample(21'sd1200);
    chk("t1_s2_spike", 32'(spike), 32'd1);
    chk("t1_s2_valid", 32'(ev_valid), 32'd1);
    chk("t1_s2_ts", 32'(ev_ts), 32'd2);
    chk("t1_s2_isi", 32'(last_isi), 32'd2);
    sample(21'sd1500);
    chk("t1_s3_spike", 32'(spike), 32'd0);
    chk("t1_s3_valid", 32'(ev_valid), 32'd0);
    sample(21'sd800);
    sample(21'sd1100);
    chk("t1_s5_spike", 32'(spike), 32'd1);
    chk("t1_s5_ts", 32'(ev_ts), 32'd5);
    chk("t1_cnt", 32'(spike_cnt), 32'd2);
    chk("t1_isi", 32'(last_isi), 32'd3);
    tick();
    chk("t1_drained", 32'(ev_valid), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'd0);

    // Back-pressure: five crossings into a 4-deep FIFO
    ev_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(21'sd0);
      sample(21'sd2000);
      if (i == 0) chk("t2_first_ts", 32'(ev_ts), 32'd1);
    end
    chk("t2_valid", 32'(ev_valid), 32'd1);
    chk("t2_head_stable", 32'(ev_ts), 32'd1);
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_cnt", 32'(spike_cnt), 32'd5);
    chk("t2_isi", 32'(last_isi), 32'd2);
    drain("t2_drain", 4, 1, 3, 5, 7);

    // Full FIFO with pop in the spike cycle: no drop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(21'sd0);
      sample(21'sd2000);
    end
    sample(21'sd0);
    chk("t3_full_ovf", 32'(ovf), 32'd0);
    ev_ready = 1'b1;
    sample(21'sd2000);
    ev_ready = 1'b0;
    chk("t3_spike", 32'(spike), 32'd1);
    chk("t3_ovf", 32'(ovf), 32'd0);
    chk("t3_cnt", 32'(spike_cnt), 32'd5);
    drain("t3_drain", 4, 3, 5, 7, 9);

    // First sample already above threshold; signed equality boundary
    do_reset();
    th = 21'sd1000;
    sample(21'sd2000);
    chk("t4_first_spike", 32'(spike), 32'd1);
    chk("t4_first_ts", 32'(ev_ts), 32'd0);
    chk("t4_first_isi", 32'(last_isi), 32'd0);
    th = -21'sd100;
    sample(-21'sd101);
    chk("t4_below_spike", 32'(spike), 32'd0);
    sample(-21'sd100);
    chk("t4_eq_spike", 32'(spike), 32'd1);
    chk("t4_cnt", 32'(spike_cnt), 32'd2);
    chk("t4_eq_ts", 32'(ev_ts), 32'd0);
    drain("t4_drain", 2, 0, 2, 0, 0);

    // Timestamp wrap: spikes at ts 65534 and 1
    do_reset();
    th       = 21'sd1000;
    ev_ready = 1'b1;
    v_in     = 21'sd0;
    v_valid  = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    v_valid = 1'b0;
    sample(21'sd2000);
    chk("t5_spike_a", 32'(spike), 32'd1);
    chk("t5_ts_a", 32'(ev_ts), 32'd65534);
    chk("t5_isi_a", 32'(last_isi), 32'd65534);
    sample(21'sd0);
    sample(21'sd0);
    sample(21'sd2000);
    chk("t5_spike_b", 32'(spike), 32'd1);
    chk("t5_ts_b", 32'(ev_ts), 32'd1);
    chk("t5_isi_b", 32'(last_isi), 32'd3);
    tick();
    ev_ready = 1'b0;

    // Refractory window sequence, then reset mid-drain
    do_reset();
    th = 21'sd1000;
    vals = '{2000, 0, 2000, 0, 0, 2000, 0};
`ifdef SPIKE_ENC_REFRACTORY_EN
    exp_sp = '{1, 0, 0, 0, 0, 1, 0};
`else
    exp_sp = '{1, 0, 1, 0, 0, 1, 0};
`endif
    for (int i = 0; i < 7; i++) begin
      sample(W'(vals[i]));
      chk("t6_spike", 32'(spike), 32'(exp_sp[i]));
    end
`ifdef SPIKE_ENC_REFRACTORY_EN
    chk("t6_cnt", 32'(spike_cnt), 32'd2);
    chk("t6_isi", 32'(last_isi), 32'd5);
    chk("t6_head", 32'(ev_ts), 32'd0);
    ev_ready = 1'b1;
    tick();
    chk("t6_second", 32'(ev_ts), 32'd5);
`else
    chk("t6_cnt", 32'(spike_cnt), 32'd3);
    chk("t6_isi", 32'(last_isi), 32'd3);
    chk("t6_head", 32'(ev_ts), 32'd0);
    ev_ready = 1'b1;
    tick();
    chk("t6_second", 32'(ev_ts), 32'd2);
`endif
    chk("t6_mid_valid", 32'(ev_valid), 32'd1);
    set = 1'b1;
    tick();
    set = 1'b0;
    chk("t6_rst_valid", 32'(ev_valid), 32'd0);
    chk("t6_rst_cnt", 32'(spike_cnt), 32'd0);
    chk("t6_rst_isi", 32'(last_isi), 32'd0);
    ev_ready = 1'b0;
    tick();
    chk("t6_rst_hold", 32'(ev_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
